// File: rtl/rop3_feeder_if.sv
// Signal bundle between the rop3 feeder, its host sequencer and the rop3 engine.
// master = feeder side, slave = host/engine environment side.
interface rop3_feeder_if #(
    parameter int N = 8
);
    // Request and response use valid/ready: a transfer happens on a rising edge
    // where valid and ready are both 1; valid and its payload hold until then.
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_p;
    logic [N-1:0] in_s;
    logic [N-1:0] in_d;
    logic [7:0]   in_mode;

    logic [N-1:0] rop_bitmap;
    logic [7:0]   rop_mode;
    logic         rop_frame;
    logic [N-1:0] rop_result;
    logic         rop_valid;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_err;
    logic         out_illegal;

    modport master (
        input  in_valid, in_p, in_s, in_d, in_mode, rop_result, rop_valid, out_ready,
        output in_ready, rop_bitmap, rop_mode, rop_frame, out_valid, out_result,
               out_err, out_illegal
    );

    modport slave (
        output in_valid, in_p, in_s, in_d, in_mode, rop_result, rop_valid, out_ready,
        input  in_ready, rop_bitmap, rop_mode, rop_frame, out_valid, out_result,
               out_err, out_illegal
    );
endinterface

// File: rtl/rop3_feeder.sv
// Takes one parallel ROP request, streams P/S/D onto the engine bitmap bus,
// waits (bounded) for the engine result and returns it with error/illegal flags.
module rop3_feeder #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           srst_n,
    rop3_feeder_if.master  bus,
    output logic [2:0]     dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_P = 3'd1,
        SEND_S = 3'd2,
        SEND_D = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t        state;
    logic [N-1:0]  s_q;
    logic [N-1:0]  d_q;
    logic [CW-1:0] cnt;

    assign dbg_state = state;

    function automatic logic mode_legal(input logic [7:0] m);
        case (m)
            8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
            8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: mode_legal = 1'b1;
            default:                                         mode_legal = 1'b0;
        endcase
    endfunction

    // Outputs are loaded on the transition into the state that presents them.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state           <= IDLE;
            s_q             <= '0;
            d_q             <= '0;
            cnt             <= '0;
            bus.in_ready    <= 1'b0;
            bus.rop_bitmap  <= '0;
            bus.rop_mode    <= '0;
            bus.rop_frame   <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_result  <= '0;
            bus.out_err     <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        bus.in_ready <= 1'b0;
                        s_q          <= bus.in_s;
                        d_q          <= bus.in_d;
                        if (mode_legal(bus.in_mode)) begin
                            state          <= SEND_P;
                            bus.rop_bitmap <= bus.in_p;
                            bus.rop_mode   <= bus.in_mode;
                            bus.rop_frame  <= 1'b1;
                        end else begin
                            state           <= RESP;
                            bus.out_valid   <= 1'b1;
                            bus.out_result  <= '0;
                            bus.out_err     <= 1'b0;
                            bus.out_illegal <= 1'b1;
                        end
                    end
                end
                SEND_P: begin
                    state          <= SEND_S;
                    bus.rop_bitmap <= s_q;
                end
                SEND_S: begin
                    state          <= SEND_D;
                    bus.rop_bitmap <= d_q;
                end
                SEND_D: begin
                    state          <= WAIT;
                    bus.rop_bitmap <= '0;
                    bus.rop_frame  <= 1'b0;
                    cnt            <= '0;
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (bus.rop_valid) begin
                        state          <= RESP;
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= bus.rop_result;
                        bus.out_err    <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state          <= RESP;
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= '0;
                        bus.out_err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        state           <= IDLE;
                        bus.in_ready    <= 1'b1;
                        bus.out_valid   <= 1'b0;
                        bus.out_err     <= 1'b0;
                        bus.out_illegal <= 1'b0;
                        bus.rop_mode    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rop3_feeder.sv
// Directed bench for rop3_feeder: reset, legal/illegal requests, timeout,
// backpressure and asynchronous reset abort, with a small engine model.
module tb_rop3_feeder;
    logic       clk = 1'b0;
    logic       srst_n;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [1:0] exp_flag_q[$];  // {err, illegal}

    rop3_feeder_if #(.N(8)) bus ();

    rop3_feeder #(.N(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine behaviour: result bit j = mode[{p[j], s[j], d[j]}]
    function automatic logic [7:0] rop3(input logic [7:0] m, p, s, d);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = m[{p[j], s[j], d[j]}];
        return r;
    endfunction

    task automatic send_req(input logic [7:0] p, s, d, mode, input logic [7:0] exp_res,
                            input logic [1:0] exp_flags);
        int w = 0;
        @(negedge clk);
        bus.in_p = p; bus.in_s = s; bus.in_d = d; bus.in_mode = mode;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_for_accept", {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back(exp_res);
        exp_flag_q.push_back(exp_flags);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // resp_cycle: WAIT cycle on which rop_valid is raised, 0 = never
    task automatic run_engine(input logic [7:0] ep, es, ed, emode, input int resp_cycle);
        int w = 0;
        @(negedge clk);
        while (!bus.rop_frame && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("frame_p", {31'd0, bus.rop_frame}, 32'd1);
        check("beat_p", {24'd0, bus.rop_bitmap}, {24'd0, ep});
        check("mode_p", {24'd0, bus.rop_mode}, {24'd0, emode});
        check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("frame_s", {31'd0, bus.rop_frame}, 32'd1);
        check("beat_s", {24'd0, bus.rop_bitmap}, {24'd0, es});
        @(negedge clk);
        check("frame_d", {31'd0, bus.rop_frame}, 32'd1);
        check("beat_d", {24'd0, bus.rop_bitmap}, {24'd0, ed});
        @(negedge clk);
        check("frame_wait", {31'd0, bus.rop_frame}, 32'd0);
        check("bitmap_wait", {24'd0, bus.rop_bitmap}, 32'd0);
        check("mode_wait", {24'd0, bus.rop_mode}, {24'd0, emode});
        if (resp_cycle > 0) begin
            repeat (resp_cycle - 1) @(negedge clk);
            check("no_early_valid", {31'd0, bus.out_valid}, 32'd0);
            bus.rop_result = rop3(emode, ep, es, ed);
            bus.rop_valid  = 1'b1;
            @(negedge clk);
            bus.rop_valid  = 1'b0;
            bus.rop_result = 8'h00;
            check("resp_latency", {31'd0, bus.out_valid}, 32'd1);
        end
    endtask

    // scoreboard: pop and compare one response, handshake with out_ready=1
    task automatic get_resp();
        int w = 0;
        logic [7:0] er;
        logic [1:0] ef;
        while (!bus.out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
            er = exp_q.pop_front();
            ef = exp_flag_q.pop_front();
            check("out_result", {24'd0, bus.out_result}, {24'd0, er});
            check("out_err", {31'd0, bus.out_err}, {31'd0, ef[1]});
            check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, ef[0]});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_clear", {31'd0, bus.out_valid}, 32'd0);
        check("flags_clear", {30'd0, bus.out_err, bus.out_illegal}, 32'd0);
        check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lows;
        srst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_p = '0; bus.in_s = '0; bus.in_d = '0; bus.in_mode = '0;
        bus.rop_result = '0; bus.rop_valid = 1'b0; bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_frame", {31'd0, bus.rop_frame}, 32'd0);
        check("rst_bitmap_mode", {16'd0, bus.rop_bitmap, bus.rop_mode}, 32'd0);
        repeat (2) @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: mode 88 -> D&S
        send_req(8'hF0, 8'hCC, 8'hAA, 8'h88, 8'h88, 2'b00);
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'h88, 1);
        get_resp();

        // 2: back-to-back 5A then FB
        send_req(8'hF0, 8'hCC, 8'hAA, 8'h5A, 8'h5A, 2'b00);
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'h5A, 2);
        get_resp();
        send_req(8'hF0, 8'hCC, 8'hAA, 8'hFB, 8'hFB, 2'b00);
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'hFB, 1);
        get_resp();

        // 3: illegal mode 12, no beats
        send_req(8'hF0, 8'hCC, 8'hAA, 8'h12, 8'h00, 2'b01);
        @(negedge clk);
        check("illegal_next_cycle", {31'd0, bus.out_valid}, 32'd1);
        check("illegal_no_frame", {31'd0, bus.rop_frame}, 32'd0);
        get_resp();

        // 4a: engine silent -> timeout after 16 WAIT cycles
        send_req(8'h0F, 8'h33, 8'h55, 8'hC0, 8'h00, 2'b10);
        run_engine(8'h0F, 8'h33, 8'h55, 8'hC0, 0);
        lows = 0;
        while (!bus.out_valid && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        check("timeout_wait_cycles", lows, 32'd16);
        get_resp();

        // 4b: result on the 16th WAIT cycle wins over timeout (P&S = 0F&33 = 03)
        send_req(8'h0F, 8'h33, 8'h55, 8'hC0, 8'h03, 2'b00);
        run_engine(8'h0F, 8'h33, 8'h55, 8'hC0, 16);
        get_resp();

        // 5: backpressure for 5 cycles, ~D = 55
        bus.out_ready = 1'b0;
        send_req(8'hF0, 8'hCC, 8'hAA, 8'h55, 8'h55, 2'b00);
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'h55, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result", {24'd0, bus.out_result}, 32'h55);
            check("bp_flags", {30'd0, bus.out_err, bus.out_illegal}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        get_resp();

        // 6: async reset during WAIT, then stray rop_valid in IDLE
        send_req(8'hF0, 8'hCC, 8'hAA, 8'hEE, 8'h00, 2'b00);
        void'(exp_q.pop_back());
        void'(exp_flag_q.pop_back());
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'hEE, 0);
        #2 srst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("abort_mode", {24'd0, bus.rop_mode}, 32'd0);
        check("abort_out", {22'd0, bus.out_valid, bus.out_result, bus.out_err}, 32'd0);
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        check("abort_release_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.rop_valid = 1'b1;
        bus.rop_result = 8'h77;
        repeat (2) begin
            @(negedge clk);
            check("stray_no_resp", {31'd0, bus.out_valid}, 32'd0);
            check("stray_no_frame", {31'd0, bus.rop_frame}, 32'd0);
        end
        bus.rop_valid = 1'b0;
        bus.rop_result = 8'h00;
        send_req(8'hF0, 8'hCC, 8'hAA, 8'hCC, 8'hCC, 2'b00);
        run_engine(8'hF0, 8'hCC, 8'hAA, 8'hCC, 3);
        get_resp();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
